// File: rtl/imm_fetch_if.sv
// imm_fetch_if: byte-stream input and extended-operand output handshake bundle for imm_fetch_ext.
interface imm_fetch_if #(
    parameter int N = 8,
    parameter int OUT_W = 16
);
    logic in_valid;
    logic in_ready;
    logic [N-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic [OUT_W-1:0] num;
    logic long_flag;
    logic err;
    modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, num, long_flag, err);
    modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, num, long_flag, err);
endinterface

// File: rtl/imm_fetch_ext.sv
// imm_fetch_ext: short/long immediate extractor between the fetch byte stream and the operand mux.
// Optional COLLECT idle timeout with one-cycle err pulse when IMM_TIMEOUT_EN is defined.
module imm_fetch_ext #(
    parameter int N = 8,
    parameter int IMM_W = 3,
    parameter int OUT_W = 16,
    parameter int EXT_BYTES = 2,
    parameter int TIMEOUT = 15
) (
    input logic clk,
    input logic rst,
    imm_fetch_if.slave bus
);
    localparam int ACC_W = EXT_BYTES * N;
    localparam int CW = $clog2(EXT_BYTES + 1);
    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [ACC_W-1:0] acc, acc_ins;
    logic [OUT_W-1:0] num;
    logic long_flag, err, take, last, abort;
    if (IMM_W > N - 2 || OUT_W < IMM_W || EXT_BYTES < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("imm_fetch_ext: illegal parameter combination");
    end
`ifdef IMM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle;
    assign abort = state == COLLECT && !bus.in_valid && idle == TW'(TIMEOUT - 1);
    always_ff @(posedge clk)
        idle <= (rst || state != COLLECT || take) ? '0 : idle + 1'b1;
`else
    assign abort = 1'b0;
`endif
    assign bus.in_ready = state != HOLD;
    assign bus.out_valid = state == HOLD;
    assign bus.num = num;
    assign bus.long_flag = long_flag;
    assign bus.err = err;
    always_comb begin
        take = bus.in_valid && state != HOLD;
        last = cnt == CW'(EXT_BYTES - 1);
        acc_ins = acc;
        acc_ins[int'(cnt)*N +: N] = bus.in_data;
        state_nxt = state;
        case (state)
            IDLE: state_nxt = take ? (bus.in_data[N-1] ? COLLECT : HOLD) : IDLE;
            COLLECT: state_nxt = (take && last) ? HOLD : (abort ? IDLE : COLLECT);
            HOLD: state_nxt = bus.out_ready ? IDLE : HOLD;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            num <= '0;
            long_flag <= 1'b0;
            err <= 1'b0;
            cnt <= '0;
            acc <= '0;
        end else begin
            state <= state_nxt;
            err <= abort;
            if (take && state == IDLE) begin
                long_flag <= bus.in_data[N-1];
                if (bus.in_data[N-1]) begin
                    cnt <= '0;
                    acc <= '0;
                end else begin
                    num <= bus.in_data[N-2] ? OUT_W'($signed(bus.in_data[IMM_W-1:0]))
                                            : OUT_W'(bus.in_data[IMM_W-1:0]);
                end
            end
            if (take && state == COLLECT) begin
                acc <= acc_ins;
                cnt <= cnt + 1'b1;
                if (last) num <= OUT_W'(acc_ins);
            end
            if (abort) begin
                acc <= '0;
                cnt <= '0;
                long_flag <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_imm_fetch_ext.sv
// tb_imm_fetch_ext: directed vector table plus hand-written multi-cycle sequences for imm_fetch_ext.
module tb_imm_fetch_ext;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    imm_fetch_if #(.N(8), .OUT_W(16)) bus ();
    imm_fetch_ext #(.N(8), .IMM_W(3), .OUT_W(16), .EXT_BYTES(2), .TIMEOUT(15)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [7:0] op;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [15:0] exp_num;
        logic exp_long;
    } vec_t;
    vec_t vecs[10];
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic send(logic [7:0] b);
        chk("in_ready_before_send", 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_data = b;
        step();
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
    initial begin
        vecs[0] = '{8'h05, 8'h00, 8'h00, 16'h0005, 1'b0};
        vecs[1] = '{8'h46, 8'h00, 8'h00, 16'hFFFE, 1'b0};
        vecs[2] = '{8'h43, 8'h00, 8'h00, 16'h0003, 1'b0};
        vecs[3] = '{8'h07, 8'h00, 8'h00, 16'h0007, 1'b0};
        vecs[4] = '{8'h3F, 8'h00, 8'h00, 16'h0007, 1'b0};
        vecs[5] = '{8'h44, 8'h00, 8'h00, 16'hFFFC, 1'b0};
        vecs[6] = '{8'h7F, 8'h00, 8'h00, 16'hFFFF, 1'b0};
        vecs[7] = '{8'h80, 8'h34, 8'h12, 16'h1234, 1'b1};
        vecs[8] = '{8'hC0, 8'hFF, 8'h7F, 16'h7FFF, 1'b1};
        vecs[9] = '{8'h81, 8'hCD, 8'hAB, 16'hABCD, 1'b1};
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset_out_valid", 32'(bus.out_valid), 0);
        chk("reset_num", 32'(bus.num), 0);
        chk("reset_long_flag", 32'(bus.long_flag), 0);
        chk("reset_err", 32'(bus.err), 0);
        chk("reset_in_ready", 32'(bus.in_ready), 1);
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].op);
            if (vecs[i].exp_long) begin
                chk("long_no_early_valid", 32'(bus.out_valid), 0);
                send(vecs[i].b0);
                chk("long_no_valid_mid", 32'(bus.out_valid), 0);
                send(vecs[i].b1);
            end
            chk("vec_out_valid", 32'(bus.out_valid), 1);
            chk("vec_num", 32'(bus.num), 32'(vecs[i].exp_num));
            chk("vec_long_flag", 32'(bus.long_flag), 32'(vecs[i].exp_long));
            chk("vec_hold_in_ready", 32'(bus.in_ready), 0);
            step();
            chk("vec_consumed", 32'(bus.out_valid), 0);
            chk("vec_num_kept", 32'(bus.num), 32'(vecs[i].exp_num));
        end
        // long form with a 3-cycle gap between immediate bytes
        send(8'h80);
        send(8'h34);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gap_out_valid", 32'(bus.out_valid), 0);
            chk("gap_in_ready", 32'(bus.in_ready), 1);
        end
        send(8'h12);
        chk("gap_out_valid_after", 32'(bus.out_valid), 1);
        chk("gap_num", 32'(bus.num), 32'h1234);
        chk("gap_long_flag", 32'(bus.long_flag), 1);
        step();
        // backpressure: a pending byte must not be taken while holding
        bus.out_ready = 1'b0;
        send(8'h07);
        bus.in_valid = 1'b1;
        bus.in_data = 8'h55;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(bus.out_valid), 1);
            chk("bp_num", 32'(bus.num), 32'h0007);
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("bp_consumed", 32'(bus.out_valid), 0);
        step();
        chk("bp_consumed_once", 32'(bus.out_valid), 0);
        chk("bp_num_kept", 32'(bus.num), 32'h0007);
        // reset in the middle of a long collection
        send(8'h80);
        send(8'h34);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_out_valid", 32'(bus.out_valid), 0);
        chk("rst_mid_num", 32'(bus.num), 0);
        chk("rst_mid_long_flag", 32'(bus.long_flag), 0);
        step();
        step();
        chk("rst_mid_nothing_emitted", 32'(bus.out_valid), 0);
        send(8'h03);
        chk("rst_after_valid", 32'(bus.out_valid), 1);
        chk("rst_after_num", 32'(bus.num), 32'h0003);
        chk("rst_after_long_flag", 32'(bus.long_flag), 0);
        step();
`ifdef IMM_TIMEOUT_EN
        send(8'h80);
        for (int i = 0; i < 14; i++) begin
            chk("to_err_low", 32'(bus.err), 0);
            step();
        end
        chk("to_err_low_last", 32'(bus.err), 0);
        step();
        chk("to_err_pulse", 32'(bus.err), 1);
        chk("to_in_ready", 32'(bus.in_ready), 1);
        chk("to_out_valid", 32'(bus.out_valid), 0);
        chk("to_long_flag", 32'(bus.long_flag), 0);
        step();
        chk("to_err_one_cycle", 32'(bus.err), 0);
        send(8'h81);
        send(8'hCD);
        send(8'hAB);
        chk("to_next_valid", 32'(bus.out_valid), 1);
        chk("to_next_num", 32'(bus.num), 32'hABCD);
`else
        send(8'h80);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("wait_err", 32'(bus.err), 0);
            chk("wait_out_valid", 32'(bus.out_valid), 0);
        end
        send(8'hCD);
        send(8'hAB);
        chk("wait_resume_valid", 32'(bus.out_valid), 1);
        chk("wait_resume_num", 32'(bus.num), 32'hABCD);
        chk("wait_resume_long", 32'(bus.long_flag), 1);
`endif
        step();
        chk("final_idle", 32'(bus.out_valid), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
